usb_tx_pkt: RTL and testbench

Packet-level USB transmitter between the transaction engine and the low-level serializer (NRZI / bit-stuff / SE0 driver). On a start strobe it builds one packet byte by byte: PID byte, then for DATAx PIDs the payload pulled from the EP TX buffer and the CRC16. Each byte goes to the serializer over a valid/ack handshake. When the serializer reports EOP done, the block pulses `pkt_done`.

---
 rtl/usb_tx_pkt_if.sv | 25 ++
 rtl/usb_tx_pkt.sv | 74 +++++++
 tb/tb_usb_tx_pkt.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/usb_tx_pkt_if.sv
// usb_tx_pkt_if: packet request/payload side and serializer byte side of the USB packet transmitter
interface usb_tx_pkt_if;
    logic       pkt_start;
    logic [3:0] pkt_pid;
    logic [9:0] pkt_len;
    logic [7:0] pkt_data;
    logic       pkt_data_ack;
    logic       pkt_done;
    logic [7:0] ll_byte;
    logic       ll_byte_valid;
    logic       ll_first;
    logic       ll_last;
    logic       ll_byte_ack;
    logic       ll_eop_done;

    modport master (
        input  pkt_start, pkt_pid, pkt_len, pkt_data, ll_byte_ack, ll_eop_done,
        output pkt_data_ack, pkt_done, ll_byte, ll_byte_valid, ll_first, ll_last
    );

    modport slave (
        output pkt_start, pkt_pid, pkt_len, pkt_data, ll_byte_ack, ll_eop_done,
        input  pkt_data_ack, pkt_done, ll_byte, ll_byte_valid, ll_first, ll_last
    );
endinterface

// File: rtl/usb_tx_pkt.sv
// usb_tx_pkt: builds PID / payload / CRC16 bytes for one USB packet and hands them to the serializer
module usb_tx_pkt (
    input logic          clk,
    input logic          rst,
    usb_tx_pkt_if.master bus
);
    typedef enum logic [2:0] {IDLE, PID, DATA, CRC_LO, CRC_HI, WAIT_EOP} state_t;

    state_t      state, state_nx;
    logic [3:0]  pid;
    logic [9:0]  cnt;
    logic [15:0] crc;
    logic        bub;
    logic        vld;
    logic        acc;
    logic        is_data;

    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c ^ {8'h00, d};
        for (int i = 0; i < 8; i++)
            r = r[0] ? (r >> 1) ^ 16'hA001 : r >> 1;
        return r;
    endfunction

    assign is_data = pid[1:0] == 2'b11;

    // state register, latched packet fields, running CRC and the one-cycle post-ack bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pid   <= 4'h0;
            cnt   <= 10'd0;
            crc   <= 16'hFFFF;
            bub   <= 1'b0;
        end else begin
            state <= state_nx;
            bub   <= acc;
            if (state == IDLE && bus.pkt_start) begin
                pid <= bus.pkt_pid;
                cnt <= bus.pkt_len;
                crc <= 16'hFFFF;
            end else if (state == DATA && acc) begin
                crc <= crc16_byte(crc, bus.pkt_data);
                cnt <= cnt - 10'd1;
            end
        end
    end

    // next state plus serializer and upstream outputs, decoded from the current state
    always_comb begin
        state_nx          = state;
        vld               = ~bub && (state == PID || state == DATA || state == CRC_LO || state == CRC_HI);
        acc               = vld && bus.ll_byte_ack;
        bus.ll_byte_valid = vld;
        bus.ll_byte       = state == PID    ? {~pid, pid} :
                            state == DATA   ? bus.pkt_data :
                            state == CRC_LO ? ~crc[7:0] :
                            state == CRC_HI ? ~crc[15:8] : 8'h00;
        bus.ll_first      = vld && state == PID;
        bus.ll_last       = vld && (state == CRC_HI || (state == PID && !is_data));
        bus.pkt_data_ack  = acc && state == DATA;
        bus.pkt_done      = state == WAIT_EOP && bus.ll_eop_done;
        case (state)
            IDLE:     if (bus.pkt_start) state_nx = PID;
            PID:      if (acc) state_nx = !is_data ? WAIT_EOP : cnt == 10'd0 ? CRC_LO : DATA;
            DATA:     if (acc && cnt == 10'd1) state_nx = CRC_LO;
            CRC_LO:   if (acc) state_nx = CRC_HI;
            CRC_HI:   if (acc) state_nx = WAIT_EOP;
            WAIT_EOP: if (bus.ll_eop_done) state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_usb_tx_pkt.sv
// tb_usb_tx_pkt: random packets against a byte-list reference model with a serializer and EP-buffer model
module tb_usb_tx_pkt;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    usb_tx_pkt_if bus();
    usb_tx_pkt dut (.clk(clk), .rst(rst), .bus(bus));

    int n_chk = 0;
    int n_fail = 0;

    logic [7:0] mem [0:1023];
    logic [9:0] addr = 10'd0;
    bit         start_ok = 0;

    logic [9:0] rx_q[$];
    logic [9:0] exp_q[$];
    int         exp_dack;
    int         n_dack;
    bit         last_seen;

    bit ser_en = 1;
    bit spur = 0;
    int gap = 1;
    bit acked = 0;
    bit post = 0;
    bit was_last = 0;
    int wcnt = 0;

    assign bus.pkt_data = mem[addr];

    // EP buffer: address restarts on an accepted start, advances on each consumed byte
    always @(posedge clk)
        if (bus.pkt_start && start_ok) addr <= 10'd0;
        else if (bus.pkt_data_ack) addr <= addr + 10'd1;

    task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
        n_chk++;
        if (got_v !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got_v, exp_v);
        end
    endtask

    // expected {first, last, byte} list; CRC computed bit-serially, LSB first
    function automatic void build_exp(input logic [3:0] pid, input int len);
        logic [15:0] c;
        logic        fb;
        bit          data;
        c = 16'hFFFF;
        data = pid[1:0] == 2'b11;
        exp_q.delete();
        exp_q.push_back({1'b1, !data, ~pid, pid});
        exp_dack = data ? len : 0;
        if (data) begin
            for (int i = 0; i < len; i++) begin
                exp_q.push_back({2'b00, mem[i]});
                for (int b = 0; b < 8; b++) begin
                    fb = c[0] ^ mem[i][b];
                    c = c >> 1;
                    if (fb) c = c ^ 16'hA001;
                end
            end
            exp_q.push_back({2'b00, ~c[7:0]});
            exp_q.push_back({2'b01, ~c[15:8]});
        end
    endfunction

    // serializer: acks after gap valid cycles, records bytes, checks the one-cycle bubble
    initial begin
        bus.ll_byte_ack = 1'b0;
        forever begin
            @(negedge clk);
            bus.ll_byte_ack = 1'b0;
            if (!ser_en) begin
                acked = 0;
                post = 0;
                wcnt = 0;
            end else if (acked) begin
                check("bubble_low", bus.ll_byte_valid, 1'b0);
                acked = 0;
                post = !was_last;
            end else begin
                if (post) begin
                    check("valid_rearm", bus.ll_byte_valid, 1'b1);
                    post = 0;
                end
                if (bus.ll_byte_valid) begin
                    wcnt++;
                    if (wcnt >= gap) begin
                        rx_q.push_back({bus.ll_first, bus.ll_last, bus.ll_byte});
                        was_last = bus.ll_last;
                        if (bus.ll_last) last_seen = 1;
                        bus.ll_byte_ack = 1'b1;
                        acked = 1;
                        wcnt = 0;
                        #1 if (bus.pkt_data_ack) n_dack++;
                    end
                end else if (spur && $urandom_range(0, 3) == 0) begin
                    bus.ll_byte_ack = 1'b1;
                end
            end
        end
    end

    task automatic issue(input logic [3:0] pid, input int len, input bit fill);
        if (fill)
            for (int i = 0; i < len + 2; i++) mem[i] = 8'($urandom);
        build_exp(pid, len);
        rx_q.delete();
        last_seen = 0;
        n_dack = 0;
        bus.pkt_pid = pid;
        bus.pkt_len = 10'(len);
        bus.pkt_start = 1'b1;
        start_ok = 1;
        @(negedge clk);
        bus.pkt_start = 1'b0;
        start_ok = 0;
        check("pid_valid", bus.ll_byte_valid, 1'b1);
        check("pid_first", bus.ll_first, 1'b1);
    endtask

    task automatic finish(input bit b2b);
        int t;
        t = 0;
        while (!last_seen && t < 5000) begin
            @(negedge clk);
            t++;
            if (t == 3) begin
                bus.pkt_start = 1'b1;
                bus.pkt_pid = 4'($urandom);
                bus.pkt_len = 10'($urandom);
            end else begin
                bus.pkt_start = 1'b0;
            end
        end
        bus.pkt_start = 1'b0;
        check("last_byte_seen", last_seen, 1'b1);
        repeat ($urandom_range(1, 3)) begin
            @(negedge clk);
            check("no_early_done", bus.pkt_done, 1'b0);
        end
        bus.ll_eop_done = 1'b1;
        if (b2b) bus.pkt_start = 1'b1;
        #1 check("pkt_done", bus.pkt_done, 1'b1);
        @(negedge clk);
        bus.ll_eop_done = 1'b0;
        bus.pkt_start = 1'b0;
        check("idle_after_done", bus.ll_byte_valid, 1'b0);
        check("done_one_cycle", bus.pkt_done, 1'b0);
        check("byte_count", rx_q.size(), exp_q.size());
        for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++)
            check($sformatf("byte%0d", i), rx_q[i], exp_q[i]);
        check("data_acks", n_dack, exp_dack);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_valid"}, bus.ll_byte_valid, 1'b0);
        check({tag, "_first"}, bus.ll_first, 1'b0);
        check({tag, "_last"}, bus.ll_last, 1'b0);
        check({tag, "_byte"}, bus.ll_byte, 8'h00);
        check({tag, "_dack"}, bus.pkt_data_ack, 1'b0);
        check({tag, "_done"}, bus.pkt_done, 1'b0);
    endtask

    initial begin
        int t;
        bit b2b;
        bus.pkt_start = 1'b0;
        bus.pkt_pid = 4'h0;
        bus.pkt_len = 10'd0;
        bus.ll_eop_done = 1'b0;
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        repeat (2) @(negedge clk);
        check_quiet("reset");
        rst = 1'b0;
        @(negedge clk);

        issue(4'h2, 7, 1);
        finish(0);
        check("ack_byte", rx_q[0], 10'h3D2);

        issue(4'h3, 0, 1);
        finish(0);
        check("data0_crc_lo", rx_q[1], 10'h000);
        check("data0_crc_hi", rx_q[2], 10'h100);

        for (int i = 0; i < 9; i++) mem[i] = 8'h31 + 8'(i);
        issue(4'hB, 9, 0);
        finish(0);
        check("check_crc_lo", rx_q[10], 10'h0C8);
        check("check_crc_hi", rx_q[11], 10'h1B4);

        gap = 40;
        issue(4'hB, 9, 0);
        finish(0);
        check("slow_crc_hi", rx_q[11], 10'h1B4);

        gap = 1;
        issue(4'hB, 9, 0);
        finish(1);
        issue(4'h3, 5, 1);
        finish(0);

        spur = 1;
        for (int k = 0; k < 16; k++) begin
            gap = $urandom_range(1, 4);
            b2b = $urandom_range(0, 1) == 1;
            issue(4'($urandom), $urandom_range(0, 60), 1);
            finish(b2b);
            if (!b2b) begin
                bus.ll_eop_done = 1'b1;
                #1 check("idle_eop_ignored", bus.pkt_done, 1'b0);
                @(negedge clk);
                bus.ll_eop_done = 1'b0;
                check("idle_eop_no_start", bus.ll_byte_valid, 1'b0);
            end
        end

        spur = 0;
        gap = 1;
        issue(4'h3, 64, 1);
        t = 0;
        while (n_dack < 3 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check("reached_byte4", n_dack >= 3, 1'b1);
        rst = 1'b1;
        ser_en = 0;
        @(negedge clk);
        rst = 1'b0;
        check_quiet("midpkt_reset");
        repeat (5) begin
            @(negedge clk);
            check("post_reset_no_done", bus.pkt_done, 1'b0);
            check("post_reset_no_dack", bus.pkt_data_ack, 1'b0);
        end
        ser_en = 1;
        issue(4'h3, 2, 1);
        finish(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
